// File: rtl/meta_done_join.sv
// Joins completions from the sequential and shuffle paths into one ordered done
// stream, tracking outstanding broadcasts and flagging id mismatches.

module meta_done_join_fifo #(
  parameter int Width = 4,
  parameter int Depth = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [Width-1:0] i_data,
  input  logic             i_pop,
  output logic [Width-1:0] o_head,
  output logic             o_empty,
  output logic             o_full
);
  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_count;

  // NOTE: storage is deliberately not reset; r_count alone decides which entries are valid.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + PtrW'(1);
      if (i_pop)  r_rptr <= r_rptr + PtrW'(1);
      r_count <= r_count + CntW'(i_push) - CntW'(i_pop);
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CntW'(Depth));
endmodule

module meta_done_join #(
  parameter int IdWidth = 4,
  parameter int Depth   = 4,
  parameter int MaxOut  = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  logic [IdWidth-1:0]       issue_id_i,
  input  logic                     seq_done_valid_i,
  output logic                     seq_done_ready_o,
  input  logic [IdWidth-1:0]       seq_done_id_i,
  input  logic                     shf_done_valid_i,
  output logic                     shf_done_ready_o,
  input  logic [IdWidth-1:0]       shf_done_id_i,
  output logic                     done_valid_o,
  input  logic                     done_ready_i,
  output logic [IdWidth-1:0]       done_id_o,
  output logic                     err_o,
  output logic [IdWidth-1:0]       err_id_o,
  output logic [$clog2(MaxOut):0]  outstanding_o,
  output logic                     idle_o
);
  localparam int OutW = $clog2(MaxOut) + 1;

  logic               r_done_valid;
  logic [IdWidth-1:0] r_done_id;
  logic               r_err;
  logic [IdWidth-1:0] r_err_id;
  logic [OutW-1:0]    r_out;

  logic               w_seq_empty, w_seq_full, w_shf_empty, w_shf_full;
  logic [IdWidth-1:0] w_seq_head, w_shf_head;
  logic               w_issue_xfer, w_seq_xfer, w_shf_xfer, w_done_xfer;
  logic               w_seq_push, w_shf_push, w_seq_drop, w_shf_drop;
  logic               w_join, w_match, w_mismatch, w_err_evt;
  logic [IdWidth-1:0] w_err_src;
  logic [OutW-1:0]    w_inc, w_dec, w_out_next;
  logic               w_unused_issue_id;

  // The issued id is informational only; nothing downstream consumes it.
  assign w_unused_issue_id = ^issue_id_i;

  assign w_issue_xfer = issue_valid_i & issue_ready_o;
  assign w_seq_xfer   = seq_done_valid_i & seq_done_ready_o;
  assign w_shf_xfer   = shf_done_valid_i & shf_done_ready_o;
  assign w_done_xfer  = r_done_valid & done_ready_i;

  // Completions arriving with nothing outstanding are spurious: dropped and flagged.
  assign w_seq_push = w_seq_xfer & (r_out != '0);
  assign w_shf_push = w_shf_xfer & (r_out != '0);
  assign w_seq_drop = w_seq_xfer & (r_out == '0);
  assign w_shf_drop = w_shf_xfer & (r_out == '0);

  assign w_join     = ~w_seq_empty & ~w_shf_empty & (~r_done_valid | done_ready_i);
  assign w_match    = (w_seq_head == w_shf_head);
  assign w_mismatch = w_join & ~w_match;
  assign w_err_evt  = w_mismatch | w_seq_drop | w_shf_drop;

  meta_done_join_fifo #(.Width(IdWidth), .Depth(Depth)) u_seq_fifo (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_push  (w_seq_push),
    .i_data  (seq_done_id_i),
    .i_pop   (w_join),
    .o_head  (w_seq_head),
    .o_empty (w_seq_empty),
    .o_full  (w_seq_full)
  );

  meta_done_join_fifo #(.Width(IdWidth), .Depth(Depth)) u_shf_fifo (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_push  (w_shf_push),
    .i_data  (shf_done_id_i),
    .i_pop   (w_join),
    .o_head  (w_shf_head),
    .o_empty (w_shf_empty),
    .o_full  (w_shf_full)
  );

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_err_src = shf_done_id_i;
    if (w_mismatch)      w_err_src = w_seq_head;
    else if (w_seq_drop) w_err_src = seq_done_id_i;

    // A late mismatch after the count already drained saturates at zero.
    w_inc      = r_out + OutW'(w_issue_xfer);
    w_dec      = OutW'(w_done_xfer) + OutW'(w_mismatch);
    w_out_next = (w_inc < w_dec) ? '0 : (w_inc - w_dec);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_done_valid <= 1'b0;
      r_done_id    <= '0;
      r_err        <= 1'b0;
      r_err_id     <= '0;
      r_out        <= '0;
    end else begin
      if (w_join && w_match) begin
        r_done_valid <= 1'b1;
        r_done_id    <= w_seq_head;
      end else if (w_done_xfer) begin
        r_done_valid <= 1'b0;
      end
      if (w_err_evt) begin
        r_err <= 1'b1;
        if (!r_err) r_err_id <= w_err_src;
      end
      r_out <= w_out_next;
    end
  end

  assign issue_ready_o    = (r_out != OutW'(MaxOut));
  assign seq_done_ready_o = ~w_seq_full;
  assign shf_done_ready_o = ~w_shf_full;
  assign done_valid_o     = r_done_valid;
  assign done_id_o        = r_done_id;
  assign err_o            = r_err;
  assign err_id_o         = r_err_id;
  assign outstanding_o    = r_out;
  assign idle_o           = (r_out == '0) & w_seq_empty & w_shf_empty & ~r_done_valid;
endmodule
